// File: rtl/trace_capture_ctrl.sv
// Capture sequencer for the trace sniffer.
// Arms on command and waits for a trigger: a match-rule hit or a rising edge
// on the M3 soft trigger. It then gates a programmable number of trace words
// into the capture FIFO, stretches a trigger pulse for the scope and reports
// status back to the register block. Everything runs in the trace clock domain.

module trace_capture_ctrl #(
   parameter int pMATCH_RULES = 8,
   parameter int pDATA_WIDTH  = 8,
   parameter int pCNT_WIDTH   = 16,
   parameter int pTRIG_WIDTH  = 4
) (
   input  logic                    trace_clk,
   input  logic                    resetn,
   input  logic                    I_arm,
   input  logic                    I_abort,
   input  logic                    I_clear,
   input  logic                    I_trig_src,
   input  logic [pMATCH_RULES-1:0] I_match_en,
   input  logic [pMATCH_RULES-1:0] I_match_hit,
   input  logic                    m3_trig,
   input  logic [pCNT_WIDTH-1:0]   I_capture_len,
   input  logic [pDATA_WIDTH-1:0]  I_word,
   input  logic                    I_word_valid,
   input  logic                    I_fifo_full,
   output logic                    O_fifo_wr,
   output logic [pDATA_WIDTH-1:0]  O_fifo_data,
   output logic                    O_trace_trig_out,
   output logic                    O_armed,
   output logic                    O_capturing,
   output logic                    O_done,
   output logic                    O_overflow,
   output logic [pCNT_WIDTH-1:0]   O_word_count
);

   // The pulse counter must hold the value pTRIG_WIDTH itself.
   localparam int PULSE_W = $clog2(pTRIG_WIDTH + 1);
   localparam logic [PULSE_W-1:0]    PULSE_LOAD = PULSE_W'(pTRIG_WIDTH);
   localparam logic [PULSE_W-1:0]    PULSE_ONE  = PULSE_W'(1);
   localparam logic [pCNT_WIDTH-1:0] CNT_MAX    = '1;
   localparam logic [pCNT_WIDTH-1:0] CNT_ONE    = pCNT_WIDTH'(1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARMED,
      ST_CAPTURE,
      ST_DONE
   } state_t;

   state_t state;
   state_t next_state;

   logic                   m3_trig_q;
   logic [PULSE_W-1:0]     pulse_cnt;

   logic                   match_event;
   logic                   m3_event;
   logic                   trig_event;
   logic                   fire;
   logic                   capture_cycle;
   logic                   accept;
   logic                   drop;
   logic                   len_limited;
   logic                   last_word;
   logic                   clear_stats;
   logic [pCNT_WIDTH-1:0]  count_inc;

   // Trigger qualification and capture-datapath decisions for this cycle.
   // The trigger cycle itself is a capture cycle, so the word presented
   // alongside the trigger becomes the first word in the FIFO. When a limit
   // is programmed, the write that reaches it ends the capture, even if that
   // write happens in the trigger cycle.
   always_comb begin
      match_event   = |(I_match_hit & I_match_en);
      m3_event      = m3_trig & ~m3_trig_q;
      trig_event    = I_trig_src ? m3_event : match_event;
      fire          = (state == ST_ARMED) & ~I_abort & trig_event;
      capture_cycle = (state == ST_CAPTURE) | fire;
      accept        = capture_cycle & I_word_valid & ~I_fifo_full;
      drop          = capture_cycle & I_word_valid & I_fifo_full;
      count_inc     = O_word_count + CNT_ONE;
      len_limited   = (I_capture_len != '0);
      last_word     = accept & len_limited & (count_inc == I_capture_len);
      clear_stats   = I_arm & ((state == ST_IDLE) |
                               ((state == ST_DONE) & ~I_clear));
   end

   // Next-state logic. Abort beats a trigger in ARMED, and clear beats
   // arm in DONE. Arm requests in ARMED or CAPTURE are ignored.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: begin
            if (I_arm) begin
               next_state = ST_ARMED;
            end
         end
         ST_ARMED: begin
            if (I_abort) begin
               next_state = ST_IDLE;
            end else if (trig_event) begin
               next_state = last_word ? ST_DONE : ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            if (I_abort || last_word) begin
               next_state = ST_DONE;
            end
         end
         ST_DONE: begin
            if (I_clear) begin
               next_state = ST_IDLE;
            end else if (I_arm) begin
               next_state = ST_ARMED;
            end
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   // State register. The status outputs are registered decodes of the
   // next state, so they line up exactly with the state register.
   always_ff @(posedge trace_clk or negedge resetn) begin
      if (!resetn) begin
         state       <= ST_IDLE;
         O_armed     <= 1'b0;
         O_capturing <= 1'b0;
         O_done      <= 1'b0;
      end else begin
         state       <= next_state;
         O_armed     <= (next_state == ST_ARMED);
         O_capturing <= (next_state == ST_CAPTURE);
         O_done      <= (next_state == ST_DONE);
      end
   end

   // The M3 trigger level is sampled every cycle in every state, so a level
   // that is already high when arming never looks like a fresh edge.
   always_ff @(posedge trace_clk or negedge resetn) begin
      if (!resetn) begin
         m3_trig_q <= 1'b0;
      end else begin
         m3_trig_q <= m3_trig;
      end
   end

   // FIFO write port, word counter and sticky overflow. A full FIFO drops the
   // word without ending the capture. The counter saturates at all-ones so an
   // unlimited capture never wraps. Arming clears the statistics; clear keeps
   // them for readback.
   always_ff @(posedge trace_clk or negedge resetn) begin
      if (!resetn) begin
         O_fifo_wr    <= 1'b0;
         O_fifo_data  <= '0;
         O_word_count <= '0;
         O_overflow   <= 1'b0;
      end else begin
         O_fifo_wr <= accept;
         if (accept) begin
            O_fifo_data <= I_word;
         end
         if (clear_stats) begin
            O_word_count <= '0;
         end else if (accept && (O_word_count != CNT_MAX)) begin
            O_word_count <= count_inc;
         end
         if (clear_stats) begin
            O_overflow <= 1'b0;
         end else if (drop) begin
            O_overflow <= 1'b1;
         end
      end
   end

   // Stretched scope trigger. The pulse starts the cycle after the trigger
   // and lasts pTRIG_WIDTH cycles. A new trigger reloads the counter, and a
   // running pulse finishes even after the state has left CAPTURE.
   always_ff @(posedge trace_clk or negedge resetn) begin
      if (!resetn) begin
         pulse_cnt        <= '0;
         O_trace_trig_out <= 1'b0;
      end else if (fire) begin
         pulse_cnt        <= PULSE_LOAD;
         O_trace_trig_out <= 1'b1;
      end else if (pulse_cnt != '0) begin
         pulse_cnt        <= pulse_cnt - PULSE_ONE;
         O_trace_trig_out <= (pulse_cnt > PULSE_ONE);
      end else begin
         O_trace_trig_out <= 1'b0;
      end
   end

endmodule
